// File: rtl/z80_bus_responder_if.sv
// ---------------------------------------------------------------------------
// z80_bus_responder_if
//   Z80 CPU bus bundle shared by a tv80-style core (master) and the
//   z80_bus_responder memory/IO model (slave).
//
//   mreq_n, iorq_n   memory / IO request strobes      (master -> slave)
//   rd_n, wr_n       read / write strobes             (master -> slave)
//   m1_n, rfsh_n     M1 cycle / refresh indicators    (master -> slave)
//   A                address, ADDR_W bits             (master -> slave)
//   cpu_do           CPU write data                   (master -> slave)
//   cpu_di           read data to the CPU             (slave  -> master)
//   wait_n           wait request, low inserts waits  (slave  -> master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface z80_bus_responder_if #(
    parameter int ADDR_W = 16
);
    logic              mreq_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic              m1_n;
    logic              rfsh_n;
    logic [ADDR_W-1:0] A;
    logic [7:0]        cpu_do;
    logic [7:0]        cpu_di;
    logic              wait_n;

    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, cpu_do,
        input  cpu_di, wait_n
    );

    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, cpu_do,
        output cpu_di, wait_n
    );
endinterface

// File: rtl/z80_bus_responder.sv
// ---------------------------------------------------------------------------
// z80_bus_responder
//   Z80-bus slave for CPU-level test harnesses. Serves memory and IO reads
//   and writes with programmable wait-state insertion, records every bus
//   write in a trace FIFO, and offers a backdoor port for preload/readback.
//
//   clk, reset_n     bus clock (rising edge) / async active-low reset
//   bus              CPU bus, slave modport (strobes, A, cpu_do, cpu_di, wait_n)
//   log_valid        trace FIFO not empty
//   log_ready        pop head entry when high together with log_valid
//   log_data         head entry {is_io, addr, data}; IO addresses zero-extended
//   log_count        FIFO occupancy
//   log_overflow     sticky, a write was dropped because the FIFO was full
//   bd_we/bd_addr/bd_wdata   backdoor memory write
//   bd_rdata         mem[bd_addr], registered, 1-cycle latency
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module z80_bus_responder #(
    parameter int ADDR_W    = 16,
    parameter int IO_ADDR_W = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int LOG_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    z80_bus_responder_if.slave           bus,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [ADDR_W+8:0]            log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow,
    input  logic                         bd_we,
    input  logic [ADDR_W-1:0]            bd_addr,
    input  logic [7:0]                   bd_wdata,
    output logic [7:0]                   bd_rdata
);

    localparam int PW = $clog2(LOG_DEPTH);
    localparam int LW = 1 + ADDR_W + 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [3:0] MEM_CNT = 4'(MEM_WAIT);
    localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(LOG_DEPTH);

    // Storage arrays: never reset so contents survive reset_n.
    logic [7:0]    mem    [2**ADDR_W];
    logic [7:0]    io_mem [2**IO_ADDR_W];
    logic [LW-1:0] log_mem[LOG_DEPTH];

    logic [1:0]        state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic              is_io_q,  is_io_d;
    logic              is_wr_q,  is_wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [7:0]        cpu_di_q, cpu_di_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic [7:0]        bd_rdata_q, bd_rdata_d;

    logic                 mem_req, io_req, inta;
    logic                 bus_wr, mem_we, io_we;
    logic                 full, pop, push_ok;
    logic [IO_ADDR_W-1:0] io_idx;
    logic [LW-1:0]        log_entry;

    // Request qualification
    always_comb begin
        mem_req = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
        io_req  = !bus.iorq_n && bus.m1_n   && (!bus.rd_n || !bus.wr_n);
        inta    = !bus.iorq_n && !bus.m1_n;
        io_idx  = addr_q[IO_ADDR_W-1:0];
    end

    // Bus FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_io_d  = is_io_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        cpu_di_d = cpu_di_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req || io_req) begin
                    // Memory wins when both requests appear together.
                    is_io_d = !mem_req;
                    is_wr_d = !bus.wr_n;
                    addr_d  = bus.A;
                    cnt_d   = mem_req ? MEM_CNT : IO_CNT;
                    state_d = (cnt_d != 4'd0) ? S_WAIT : S_ACCESS;
                end else if (inta) begin
                    cpu_di_d = 8'hFF;
                end
            end
            S_WAIT: begin
                // Leaving at count 1 keeps wait_n low for exactly N clocks.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!is_wr_q) begin
                    cpu_di_d = is_io_q ? io_mem[io_idx] : mem[addr_q];
                end
                state_d = S_HOLD;
            end
            default: begin
                // HOLD: one access per bus cycle, wait for strobes to drop.
                if (bus.rd_n && bus.wr_n) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Write strobes and trace FIFO control
    always_comb begin
        bus_wr    = (state_q == S_ACCESS) && is_wr_q;
        mem_we    = bus_wr && !is_io_q;
        io_we     = bus_wr && is_io_q;
        log_entry = {is_io_q,
                     is_io_q ? ADDR_W'(addr_q[IO_ADDR_W-1:0]) : addr_q,
                     bus.cpu_do};

        full    = (count_q == FULL_CNT);
        pop     = log_ready && (count_q != '0);
        // A pop frees the slot in the same cycle, so a full FIFO still
        // accepts a push that coincides with a pop.
        push_ok = bus_wr && (!full || pop);

        wr_ptr_d = wr_ptr_q + (push_ok ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (PW + 1)'(1);
        end
        ovf_d = ovf_q || (bus_wr && !push_ok);

        bd_rdata_d = mem[bd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_io_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            cpu_di_q   <= 8'hFF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            bd_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_io_q    <= is_io_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            cpu_di_q   <= cpu_di_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            bd_rdata_q <= bd_rdata_d;
        end
    end

    // Memory: the bus write is issued last so it wins a same-address
    // collision with the backdoor; different addresses both land.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (mem_we) begin
            mem[addr_q] <= bus.cpu_do;
        end
    end

    always_ff @(posedge clk) begin
        if (io_we) begin
            io_mem[io_idx] <= bus.cpu_do;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_mem[wr_ptr_q] <= log_entry;
        end
    end

    assign bus.cpu_di   = cpu_di_q;
    assign bus.wait_n   = (state_q != S_WAIT);
    assign log_valid    = (count_q != '0);
    assign log_data     = log_mem[rd_ptr_q];
    assign log_count    = count_q;
    assign log_overflow = ovf_q;
    assign bd_rdata     = bd_rdata_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
`timescale 1ns/1ps

module tb_z80_bus_responder;

    logic        clk;
    logic        reset_n;
    logic        log_valid;
    logic        log_ready;
    logic [24:0] log_data;
    logic [2:0]  log_count;
    logic        log_overflow;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_wdata;
    logic [7:0]  bd_rdata;

    int errors = 0;
    int checks = 0;
    int waits;
    logic [7:0] rd;
    bit         saw_log;

    z80_bus_responder_if #(.ADDR_W(16)) bus_if ();

    z80_bus_responder #(
        .ADDR_W    (16),
        .IO_ADDR_W (8),
        .MEM_WAIT  (0),
        .IO_WAIT   (3),
        .LOG_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus_if),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_data     (log_data),
        .log_count    (log_count),
        .log_overflow (log_overflow),
        .bd_we        (bd_we),
        .bd_addr      (bd_addr),
        .bd_wdata     (bd_wdata),
        .bd_rdata     (bd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_release();
        bus_if.mreq_n = 1'b1;
        bus_if.iorq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        bus_if.wr_n   = 1'b1;
        bus_if.m1_n   = 1'b1;
        bus_if.rfsh_n = 1'b1;
    endtask

    // Full bus cycle: returns wait clocks seen, cpu_di after ACCESS and
    // whether log_valid was observed high at any point.
    task automatic bus_cycle(input bit io, input bit wr, input logic [15:0] addr,
                             input logic [7:0] d, output int nw,
                             output logic [7:0] rdv, output bit logseen);
        bus_if.A      = addr;
        bus_if.cpu_do = d;
        if (io) bus_if.iorq_n = 1'b0; else bus_if.mreq_n = 1'b0;
        if (wr) bus_if.wr_n = 1'b0;   else bus_if.rd_n = 1'b0;
        nw = 0;
        logseen = 1'b0;
        tick();
        while (bus_if.wait_n === 1'b0 && nw < 32) begin
            nw++;
            if (log_valid) logseen = 1'b1;
            tick();
        end
        tick();
        rdv = bus_if.cpu_di;
        if (log_valid) logseen = 1'b1;
        bus_release();
        tick();
    endtask

    task automatic pop1();
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        log_ready = 1'b0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_wdata  = '0;
        bus_if.A      = '0;
        bus_if.cpu_do = '0;
        bus_release();
        tick();
        tick();
        chk("rst_wait_n", 32'(bus_if.wait_n), 32'h1);
        chk("rst_cpu_di", 32'(bus_if.cpu_di), 32'hFF);
        chk("rst_log_valid", 32'(log_valid), 32'h0);
        chk("rst_log_count", 32'(log_count), 32'h0);
        chk("rst_overflow", 32'(log_overflow), 32'h0);
        chk("rst_bd_rdata", 32'(bd_rdata), 32'h0);
        reset_n = 1'b1;
        tick();

        // Backdoor preload mem[0000]=A4 and readback
        bd_we = 1'b1; bd_addr = 16'h0000; bd_wdata = 8'hA4;
        tick();
        bd_we = 1'b0;
        tick();
        chk("bd_preload", 32'(bd_rdata), 32'hA4);

        // Zero-wait M1 read
        bus_if.A = 16'h0000; bus_if.mreq_n = 1'b0; bus_if.rd_n = 1'b0; bus_if.m1_n = 1'b0;
        tick();
        chk("zw_wait_n_1", 32'(bus_if.wait_n), 32'h1);
        tick();
        chk("zw_wait_n_2", 32'(bus_if.wait_n), 32'h1);
        chk("zw_cpu_di", 32'(bus_if.cpu_di), 32'hA4);
        bus_release();
        tick();
        tick();
        chk("zw_cpu_di_hold", 32'(bus_if.cpu_di), 32'hA4);

        // IO write to port 42, three wait states, then trace entry
        bus_cycle(1'b1, 1'b1, 16'h0042, 8'h5A, waits, rd, saw_log);
        chk("iow_waits", 32'(waits), 32'd3);
        chk("iow_log", 32'(log_data), 32'h100425A);
        pop1();
        chk("iow_popped", 32'(log_valid), 32'h0);

        // IO read of port 42
        bus_cycle(1'b1, 1'b0, 16'h0042, 8'h00, waits, rd, saw_log);
        chk("ior_waits", 32'(waits), 32'd3);
        chk("ior_data", 32'(rd), 32'h5A);
        chk("ior_no_log", 32'(saw_log), 32'h0);

        // Write trace: memory then IO
        bus_cycle(1'b0, 1'b1, 16'hDCA6, 8'h49, waits, rd, saw_log);
        bus_cycle(1'b1, 1'b1, 16'h0010, 8'h77, waits, rd, saw_log);
        chk("trace_count", 32'(log_count), 32'd2);
        chk("trace_head0", 32'(log_data), 32'h00DCA649);
        pop1();
        chk("trace_head1", 32'(log_data), 32'h01001077);
        pop1();
        chk("trace_empty", 32'(log_count), 32'd0);
        bd_addr = 16'hDCA6;
        tick();
        chk("trace_bd_rdata", 32'(bd_rdata), 32'h49);

        // Overflow: five writes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            bus_cycle(1'b0, 1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i), waits, rd, saw_log);
        end
        chk("ovf_count", 32'(log_count), 32'd4);
        chk("ovf_flag", 32'(log_overflow), 32'h1);
        chk("ovf_head", 32'(log_data), 32'h00010010);
        // Sixth write pushes in the same cycle as a pop
        bus_if.A = 16'h0105; bus_if.cpu_do = 8'h15;
        bus_if.mreq_n = 1'b0; bus_if.wr_n = 1'b0;
        tick();
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        chk("pushpop_count", 32'(log_count), 32'd4);
        chk("pushpop_head", 32'(log_data), 32'h00010111);
        bus_release();
        tick();
        pop1(); pop1(); pop1();
        chk("ovf_tail", 32'(log_data), 32'h00010515);
        pop1();
        chk("drained", 32'(log_count), 32'd0);
        pop1();
        chk("pop_empty", 32'(log_count), 32'd0);
        chk("ovf_sticky", 32'(log_overflow), 32'h1);

        // Collision: bus write 11 and backdoor 22 to 1234 in the same cycle
        bus_if.A = 16'h1234; bus_if.cpu_do = 8'h11;
        bus_if.mreq_n = 1'b0; bus_if.wr_n = 1'b0;
        tick();
        bd_we = 1'b1; bd_addr = 16'h1234; bd_wdata = 8'h22;
        tick();
        bd_we = 1'b0;
        bus_release();
        tick();
        tick();
        chk("collide_same", 32'(bd_rdata), 32'h11);
        // Different addresses both land
        bus_if.A = 16'h1235; bus_if.cpu_do = 8'h44;
        bus_if.mreq_n = 1'b0; bus_if.wr_n = 1'b0;
        tick();
        bd_we = 1'b1; bd_addr = 16'h2000; bd_wdata = 8'h33;
        tick();
        bd_we = 1'b0;
        bus_release();
        tick();
        tick();
        chk("collide_bd", 32'(bd_rdata), 32'h33);
        bd_addr = 16'h1235;
        tick();
        chk("collide_bus", 32'(bd_rdata), 32'h44);
        // Read-during-write returns the old value
        bd_we = 1'b1; bd_addr = 16'h1234; bd_wdata = 8'h55;
        tick();
        bd_we = 1'b0;
        chk("rdw_old", 32'(bd_rdata), 32'h11);
        tick();
        chk("rdw_new", 32'(bd_rdata), 32'h55);
        for (int i = 0; i < 6 && log_valid; i++) pop1();
        chk("drain2", 32'(log_count), 32'd0);

        // Refresh cycle is ignored
        bus_if.A = 16'h1234; bus_if.cpu_do = 8'h99;
        bus_if.mreq_n = 1'b0; bus_if.rfsh_n = 1'b0; bus_if.wr_n = 1'b0;
        tick(); tick(); tick();
        chk("rfsh_no_log", 32'(log_count), 32'd0);
        chk("rfsh_wait_n", 32'(bus_if.wait_n), 32'h1);
        bus_release();
        tick();
        chk("rfsh_mem", 32'(bd_rdata), 32'h55);

        // Interrupt acknowledge drives FF
        bus_if.iorq_n = 1'b0; bus_if.m1_n = 1'b0;
        tick();
        chk("inta_ff", 32'(bus_if.cpu_di), 32'hFF);
        bus_release();
        tick();

        // Reset during WAIT with a pending trace entry
        bus_cycle(1'b0, 1'b1, 16'h3000, 8'h66, waits, rd, saw_log);
        chk("pre_rst_count", 32'(log_count), 32'd1);
        bus_if.A = 16'h0042; bus_if.iorq_n = 1'b0; bus_if.rd_n = 1'b0;
        tick();
        tick();
        chk("mid_wait_low", 32'(bus_if.wait_n), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_wait_n", 32'(bus_if.wait_n), 32'h1);
        chk("async_log_valid", 32'(log_valid), 32'h0);
        chk("async_count", 32'(log_count), 32'd0);
        chk("async_ovf", 32'(log_overflow), 32'h0);
        bus_release();
        tick();
        reset_n = 1'b1;
        tick();
        bus_cycle(1'b0, 1'b0, 16'hDCA6, 8'h00, waits, rd, saw_log);
        chk("post_rst_waits", 32'(waits), 32'd0);
        chk("post_rst_mem", 32'(rd), 32'h49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Parametrised Z80-bus slave that replaces the ad-hoc negedge memory/IO arrays in CPU-level test harnesses.
- Serves memory and IO reads and writes for a tv80-style core, with programmable wait-state insertion (drives wait_n).
- Keeps a write-trace FIFO so benches can check bus writes in order.
- Has a backdoor port, so SETMEM/ASSERTMEM-style preload and readback need no hierarchical references.

Parameters:
- ADDR_W, 16, memory address width; memory depth is 2**ADDR_W bytes.
- IO_ADDR_W, 8, IO address width; taken from A[IO_ADDR_W-1:0].
- MEM_WAIT, 0, wait cycles inserted per memory access (0..15).
- IO_WAIT, 1, wait cycles inserted per IO access (0..15).
- LOG_DEPTH, 16, write-trace FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single bus clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mreq_n  in  1  CPU memory request.
- iorq_n  in  1  CPU IO request.
- rd_n  in  1  CPU read strobe.
- wr_n  in  1  CPU write strobe.
- m1_n  in  1  CPU M1 cycle.
- rfsh_n  in  1  CPU refresh.
- A  in  ADDR_W  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  read data to the CPU; registered.
- wait_n  out  1  wait request to the CPU; low while wait cycles are being inserted.
- log_valid  out  1  trace FIFO not empty.
- log_ready  in  1  consumer pops the head entry when high together with log_valid.
- log_data  out  1+ADDR_W+8  head entry: {is_io, addr, data}; IO entries zero-extend the address.
- log_count  out  $clog2(LOG_DEPTH)+1  current occupancy.
- log_overflow  out  1  sticky; set when a write had to be dropped.
- bd_we  in  1  backdoor write enable (memory only).
- bd_addr  in  ADDR_W  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  mem[bd_addr], registered, 1-cycle latency.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, wait_n=1, cpu_di=8'hFF.
  - FIFO emptied: log_valid=0, log_count=0, log_overflow=0; bd_rdata=0.
  - Memory and IO arrays are not cleared; contents survive reset, including a reset mid-access.
- Request qualification, sampled at posedge in IDLE:
  - mem_req = !mreq_n & rfsh_n & (!rd_n | !wr_n).
  - io_req = !iorq_n & m1_n & (!rd_n | !wr_n).
  - Interrupt acknowledge (!iorq_n & !m1_n) is not a request; cpu_di is driven 8'hFF for it.
  - Refresh cycles (!rfsh_n) are ignored.
  - If mem_req and io_req are both true, mem_req wins.
- FSM states: IDLE, WAIT, ACCESS, HOLD.
- IDLE:
  - On a qualified request, capture the type (mem/io), direction (rd/wr), address and data.
  - Load the wait counter with MEM_WAIT or IO_WAIT.
  - Next state is WAIT if the count is nonzero, else ACCESS.
- WAIT:
  - wait_n=0 (decoded from state, no extra register).
  - Counter decrements each clock; when it reaches 1, go to ACCESS.
  - wait_n is therefore low for exactly N clocks.
- ACCESS (one clock):
  - Read: cpu_di <= array[addr].
  - Write: array[addr] <= data sampled from cpu_do in this cycle, and push {is_io, addr, data} to the FIFO.
  - Then go to HOLD.
- HOLD:
  - Stay until rd_n & wr_n are both 1, then go to IDLE.
  - One bus cycle produces exactly one access, however long the strobe is held.
- Read latency:
  - Zero-wait read: cpu_di is valid 2 clocks after the request is first sampled.
  - N-wait read: 2+N clocks.
- cpu_di holds its last value between reads.
- FIFO:
  - Push when full: the entry is dropped and log_overflow is set.
  - Push and pop in the same cycle when full: both succeed and count is unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo LOG_DEPTH.
- Backdoor:
  - bd_we writes memory at posedge.
  - If bd_we and a bus ACCESS write hit the same address in the same cycle, the bus write wins.
  - Different addresses: both writes land.
  - bd_rdata returns the pre-write value on a same-cycle read-during-write.

Test Plan:
- Zero-wait read: backdoor mem[16'h0000]=8'hA4; MEM_WAIT=0; drive an M1 read at 16'h0000 -> wait_n stays 1; cpu_di=8'hA4 two clocks after the request.
- Wait insertion: IO_WAIT=3; IO read of port 8'h42 preloaded with 8'h5A -> wait_n low exactly 3 clocks; cpu_di=8'h5A at 5 clocks; log_valid stays 0.
- Write trace: memory writes 16'hDCA6<=8'h49 then IO 8'h10<=8'h77 -> log_data=={0,16'hDCA6,8'h49} then {1,16'h0010,8'h77}; bd_rdata at 16'hDCA6 = 8'h49.
- Overflow: LOG_DEPTH=4, log_ready=0, 5 writes -> log_count=4, log_overflow=1, head is the first write. Then pop with a simultaneous 6th write -> count stays 4.
- Collision and refresh: bus write 8'h11 and backdoor write 8'h22 to 16'h1234 in the same cycle -> mem=8'h11. Refresh cycle with mreq_n=0, rfsh_n=0 -> no access, no log entry.
- Reset mid-access: assert reset_n=0 during WAIT -> wait_n=1 immediately (async); FSM in IDLE; FIFO empty; previously written mem[16'hDCA6]=8'h49 still readable.
